// File: rtl/cgra_pkg.sv
// Shared constants, descriptor layout, FSM state type and small helpers for the CGRA controller.
package cgra_pkg;

    localparam int N_COL               = 4;
    localparam int KER_CONF_N_REG_LOG2 = 4;
    localparam int RCS_NUM_CREG_LOG2   = 5;
    localparam int RC_INSTR_N_REG_LOG2 = 9;
    localparam int KMEM_WIDTH          = N_COL + RC_INSTR_N_REG_LOG2 + RCS_NUM_CREG_LOG2;

    // Descriptor layout: {col_mask, imem_start, n_lines-1}
    localparam int DESC_NL_LSB    = 0;
    localparam int DESC_START_LSB = RCS_NUM_CREG_LOG2;
    localparam int DESC_MASK_LSB  = RCS_NUM_CREG_LOG2 + RC_INSTR_N_REG_LOG2;

    // Line counter must hold N_COL * 2^RCS_NUM_CREG_LOG2
    localparam int COL_IDX_W = $clog2(N_COL);
    localparam int CNT_W     = $clog2(N_COL) + RCS_NUM_CREG_LOG2 + 1;

    localparam logic [RCS_NUM_CREG_LOG2-1:0] PC_ONE  = {{(RCS_NUM_CREG_LOG2-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]             CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef logic [COL_IDX_W-1:0] col_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_START = 3'd3,
        ST_EXEC  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic col_idx_t lowest_set(input logic [N_COL-1:0] v);
        col_idx_t idx;
        idx = '0;
        for (int i = N_COL - 1; i >= 0; i--) begin
            if (v[i]) idx = col_idx_t'(i);
        end
        return idx;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [N_COL-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_COL; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cgra_ctrl_pc.sv
// Per-column program counter: clear on start, branch or increment (wrapping) when enabled.
module cgra_ctrl_pc
    import cgra_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic                         br_req_i,
    input  logic [RCS_NUM_CREG_LOG2-1:0] br_add_i,
    output logic [RCS_NUM_CREG_LOG2-1:0] pc_o
);

    logic [RCS_NUM_CREG_LOG2-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (en_i) begin
            pc_d = br_req_i ? br_add_i : (pc_q + PC_ONE);
        end else begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/cgra_ctrl.sv
// CGRA controller: accepts launches, streams config lines from imem, then runs columns in lockstep.
// Define CGRA_CTRL_CONF_CACHE_EN to skip reloading when kernel id and mask match the last load.
module cgra_ctrl
    import cgra_pkg::*;
(
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [N_COL-1:0]                           acc_req_i,
    output logic [KER_CONF_N_REG_LOG2-1:0]             ker_id_req_o,
    input  logic [KER_CONF_N_REG_LOG2-1:0]             ker_id_req_i,
    input  logic [KMEM_WIDTH-1:0]                      kmem_rdata_i,
    input  logic                                       imem_gnt_ctrl_i,
    input  logic                                       imem_rvalid_ctrl_i,
    input  logic [N_COL-1:0]                           data_stall_i,
    input  logic [N_COL-1:0]                           rcs_stall_i,
    input  logic [N_COL-1:0]                           rcs_br_req_i,
    input  logic [N_COL-1:0][RCS_NUM_CREG_LOG2-1:0]    rcs_br_add_i,
    input  logic [N_COL-1:0]                           rcs_exec_end_i,
    output logic                                       rcs_conf_req_o,
    output logic [RC_INSTR_N_REG_LOG2-1:0]             imem_radd_o,
    output logic [N_COL-1:0]                           rcs_conf_we_o,
    output logic [N_COL-1:0]                           rcs_conf_re_o,
    output logic [N_COL-1:0]                           rcs_pc_e_o,
    output logic [N_COL-1:0][RCS_NUM_CREG_LOG2-1:0]    rcs_pc_o,
    output logic [N_COL-1:0]                           col_e_o,
    output logic [N_COL-1:0]                           rcs_rst_col_o,
    output logic [N_COL-1:0]                           rcs_conf_ack_o,
    output logic [N_COL-1:0]                           col_start_o,
    output logic                                       acc_ack_o,
    output logic [N_COL-1:0]                           acc_end_o
);

    state_e                           state_q, state_d;
    logic [N_COL-1:0]                 slot_q, slot_d, mask_q, mask_d;
    logic [KER_CONF_N_REG_LOG2-1:0]   ker_id_q, ker_id_d;
    logic [RC_INSTR_N_REG_LOG2-1:0]   start_q, start_d;
    logic [RCS_NUM_CREG_LOG2-1:0]     nlast_q, nlast_d, rcv_line_q, rcv_line_d;
    logic [CNT_W-1:0]                 total_q, total_d, req_cnt_q, req_cnt_d;
    col_idx_t                         rcv_col_q, rcv_col_d;

    logic [N_COL-1:0]                 desc_mask_s, above_s, pc_clr_s, pc_e_s, we_s;
    logic [RC_INSTR_N_REG_LOG2-1:0]   desc_start_s;
    logic [RCS_NUM_CREG_LOG2-1:0]     desc_nlast_s;
    logic [CNT_W-1:0]                 n_lines_s;
    logic [N_COL-1:0][RCS_NUM_CREG_LOG2-1:0] pc_s;
    logic                             stall_s, end_s;

`ifdef CGRA_CTRL_CONF_CACHE_EN
    logic                             cache_vld_q, cache_vld_d, hit_q, hit_d;
    logic [KER_CONF_N_REG_LOG2-1:0]   cache_id_q, cache_id_d;
    logic [N_COL-1:0]                 cache_mask_q, cache_mask_d;
`endif

    assign desc_mask_s  = kmem_rdata_i[DESC_MASK_LSB +: N_COL];
    assign desc_start_s = kmem_rdata_i[DESC_START_LSB +: RC_INSTR_N_REG_LOG2];
    assign desc_nlast_s = kmem_rdata_i[DESC_NL_LSB +: RCS_NUM_CREG_LOG2];
    assign n_lines_s    = CNT_W'(desc_nlast_s) + CNT_ONE;

    assign stall_s = |((data_stall_i | rcs_stall_i) & mask_q);
    assign end_s   = (mask_q != {N_COL{1'b0}}) && ((rcs_exec_end_i & mask_q) == mask_q);

    // Masked columns strictly above the one currently receiving lines
    always_comb begin
        above_s = '0;
        for (int i = 0; i < N_COL; i++) begin
            above_s[i] = mask_q[i] & (i > int'(rcv_col_q));
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d        = state_q;
        slot_d         = slot_q;
        mask_d         = mask_q;
        ker_id_d       = ker_id_q;
        start_d        = start_q;
        nlast_d        = nlast_q;
        total_d        = total_q;
        req_cnt_d      = req_cnt_q;
        rcv_col_d      = rcv_col_q;
        rcv_line_d     = rcv_line_q;
`ifdef CGRA_CTRL_CONF_CACHE_EN
        cache_vld_d    = cache_vld_q;
        cache_id_d     = cache_id_q;
        cache_mask_d   = cache_mask_q;
        hit_d          = hit_q;
`endif
        acc_ack_o      = 1'b0;
        acc_end_o      = '0;
        rcs_conf_req_o = 1'b0;
        imem_radd_o    = '0;
        we_s           = '0;
        rcs_conf_re_o  = '0;
        pc_e_s         = '0;
        pc_clr_s       = '0;
        col_e_o        = '0;
        rcs_rst_col_o  = '0;
        rcs_conf_ack_o = '0;
        col_start_o    = '0;

        case (state_q)
            ST_IDLE: begin
                if (acc_req_i != {N_COL{1'b0}}) begin
                    // Isolate lowest set request bit
                    slot_d   = acc_req_i & (~acc_req_i + {{(N_COL-1){1'b0}}, 1'b1});
                    ker_id_d = ker_id_req_i;
                    state_d  = ST_ACK;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ACK: begin
                acc_ack_o  = 1'b1;
                mask_d     = desc_mask_s;
                start_d    = desc_start_s;
                nlast_d    = desc_nlast_s;
                total_d    = popcount(desc_mask_s) * n_lines_s;
                req_cnt_d  = '0;
                rcv_col_d  = lowest_set(desc_mask_s);
                rcv_line_d = '0;
                if (desc_mask_s == {N_COL{1'b0}}) begin
                    state_d = ST_DONE;
`ifdef CGRA_CTRL_CONF_CACHE_EN
                end else if (cache_vld_q && (cache_id_q == ker_id_q) && (cache_mask_q == desc_mask_s)) begin
                    hit_d   = 1'b1;
                    state_d = ST_START;
`endif
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                col_e_o       = mask_q;
                rcs_rst_col_o = ~mask_q;
                if (req_cnt_q < total_q) begin
                    rcs_conf_req_o = 1'b1;
                    imem_radd_o    = start_q + RC_INSTR_N_REG_LOG2'(req_cnt_q);
                    if (imem_gnt_ctrl_i) req_cnt_d = req_cnt_q + CNT_ONE;
                    else                 req_cnt_d = req_cnt_q;
                end else begin
                    rcs_conf_req_o = 1'b0;
                end
                if (imem_rvalid_ctrl_i) begin
                    we_s[rcv_col_q] = 1'b1;
                    if (rcv_line_q == nlast_q) begin
                        rcs_conf_ack_o[rcv_col_q] = 1'b1;
                        rcv_line_d = '0;
                        if (above_s == {N_COL{1'b0}}) begin
                            state_d = ST_START;
`ifdef CGRA_CTRL_CONF_CACHE_EN
                            cache_vld_d  = 1'b1;
                            cache_id_d   = ker_id_q;
                            cache_mask_d = mask_q;
`endif
                        end else begin
                            rcv_col_d = lowest_set(above_s);
                        end
                    end else begin
                        rcv_line_d = rcv_line_q + PC_ONE;
                    end
                end else begin
                    rcv_line_d = rcv_line_q;
                end
            end
            ST_START: begin
                col_e_o       = mask_q;
                col_start_o   = mask_q;
                rcs_rst_col_o = {N_COL{1'b1}};
                pc_clr_s      = mask_q;
`ifdef CGRA_CTRL_CONF_CACHE_EN
                if (hit_q) rcs_conf_ack_o = mask_q;
                else       rcs_conf_ack_o = {N_COL{1'b0}};
                hit_d = 1'b0;
`else
                rcs_conf_ack_o = {N_COL{1'b0}};
`endif
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                col_e_o       = mask_q;
                rcs_rst_col_o = ~mask_q;
                rcs_conf_re_o = mask_q;
                pc_e_s        = stall_s ? {N_COL{1'b0}} : mask_q;
                if (end_s) begin
                    acc_end_o = slot_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d   = ST_EXEC;
                end
            end
            ST_DONE: begin
                acc_end_o = slot_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            mask_q     <= '0;
            ker_id_q   <= '0;
            start_q    <= '0;
            nlast_q    <= '0;
            total_q    <= '0;
            req_cnt_q  <= '0;
            rcv_col_q  <= '0;
            rcv_line_q <= '0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            mask_q     <= mask_d;
            ker_id_q   <= ker_id_d;
            start_q    <= start_d;
            nlast_q    <= nlast_d;
            total_q    <= total_d;
            req_cnt_q  <= req_cnt_d;
            rcv_col_q  <= rcv_col_d;
            rcv_line_q <= rcv_line_d;
        end
    end

`ifdef CGRA_CTRL_CONF_CACHE_EN
    // Last-loaded kernel cache
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cache_vld_q  <= 1'b0;
            cache_id_q   <= '0;
            cache_mask_q <= '0;
            hit_q        <= 1'b0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_id_q   <= cache_id_d;
            cache_mask_q <= cache_mask_d;
            hit_q        <= hit_d;
        end
    end
`endif

    for (genvar c = 0; c < N_COL; c++) begin : g_pc
        cgra_ctrl_pc u_pc (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clr_i    (pc_clr_s[c]),
            .en_i     (pc_e_s[c]),
            .br_req_i (rcs_br_req_i[c]),
            .br_add_i (rcs_br_add_i[c]),
            .pc_o     (pc_s[c])
        );
    end

    // During load the PC bus carries the write index of the arriving line
    always_comb begin
        rcs_pc_o = pc_s;
        for (int c = 0; c < N_COL; c++) begin
            if (we_s[c]) rcs_pc_o[c] = rcv_line_q;
            else         rcs_pc_o[c] = pc_s[c];
        end
    end

    assign ker_id_req_o  = ker_id_q;
    assign rcs_conf_we_o = we_s;
    assign rcs_pc_e_o    = pc_e_s;

endmodule

// File: tb/tb_cgra_ctrl.sv
// Directed self-checking bench for cgra_ctrl with a small kmem table and a 1-cycle imem responder.
module tb_cgra_ctrl;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      acc_req = 4'b0, ker_id = 4'b0;
    logic [3:0]      data_stall = 4'b0, rcs_stall = 4'b0, br_req = 4'b0, exec_end = 4'b0;
    logic [3:0][4:0] br_add = '0;
    logic [17:0]     kmem;
    logic            gnt_en = 1'b1;
    logic            imem_gnt;
    logic            imem_rvalid = 1'b0;

    logic [3:0]      ker_id_o, conf_we, conf_re, pc_e, col_e, rst_col, conf_ack, col_start, acc_end;
    logic [3:0][4:0] rcs_pc;
    logic [8:0]      imem_radd;
    logic            conf_req, acc_ack;

    int n_checks = 0;
    int n_pass   = 0;
    int addr_log[$];
    int we_log[$];
    logic [3:0] ack_log[$];

    cgra_ctrl dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .acc_req_i          (acc_req),
        .ker_id_req_o       (ker_id_o),
        .ker_id_req_i       (ker_id),
        .kmem_rdata_i       (kmem),
        .imem_gnt_ctrl_i    (imem_gnt),
        .imem_rvalid_ctrl_i (imem_rvalid),
        .data_stall_i       (data_stall),
        .rcs_stall_i        (rcs_stall),
        .rcs_br_req_i       (br_req),
        .rcs_br_add_i       (br_add),
        .rcs_exec_end_i     (exec_end),
        .rcs_conf_req_o     (conf_req),
        .imem_radd_o        (imem_radd),
        .rcs_conf_we_o      (conf_we),
        .rcs_conf_re_o      (conf_re),
        .rcs_pc_e_o         (pc_e),
        .rcs_pc_o           (rcs_pc),
        .col_e_o            (col_e),
        .rcs_rst_col_o      (rst_col),
        .rcs_conf_ack_o     (conf_ack),
        .col_start_o        (col_start),
        .acc_ack_o          (acc_ack),
        .acc_end_o          (acc_end)
    );

    always #5 clk = ~clk;

    // Kernel descriptor table {mask, imem_start, n_lines-1}
    always_comb begin
        case (ker_id_o)
            4'd3:    kmem = {4'b0011, 9'd16,  5'd2};
            4'd5:    kmem = {4'b0000, 9'd40,  5'd1};
            4'd6:    kmem = {4'b0100, 9'd510, 5'd3};
            default: kmem = 18'd0;
        endcase
    end

    assign imem_gnt = conf_req & gnt_en;

    always @(posedge clk or posedge rst) begin
        if (rst) imem_rvalid <= 1'b0;
        else     imem_rvalid <= conf_req & imem_gnt;
    end

    always @(negedge clk) begin
        if (conf_req && imem_gnt) addr_log.push_back(int'(imem_radd));
        for (int c = 0; c < 4; c++) begin
            if (conf_we[c]) we_log.push_back(c * 32 + int'(rcs_pc[c]));
        end
        if (conf_ack != 4'b0) ack_log.push_back(conf_ack);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_logs();
        addr_log.delete();
        we_log.delete();
        ack_log.delete();
    endtask

    task automatic launch(input logic [3:0] req, input logic [3:0] kid);
        int n;
        clear_logs();
        ker_id  = kid;
        acc_req = req;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!acc_ack && n < 20);
        check_eq("acc_ack", {31'b0, acc_ack}, 32'd1);
        acc_req = 4'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (col_start == 4'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("start_seen", {31'b0, (col_start != 4'b0)}, 32'd1);
    endtask

    task automatic end_kernel(input logic [3:0] mask, input logic [3:0] slot);
        @(negedge clk);
        exec_end = mask;
        #1;
        check_eq("acc_end", {28'b0, acc_end}, {28'b0, slot});
        @(negedge clk);
        exec_end = 4'b0;
        #1;
        check_eq("col_e_off", {28'b0, col_e}, 32'd0);
    endtask

    task automatic check_addrs(input int base, input int n);
        check_eq("addr_cnt", addr_log.size(), n);
        for (int i = 0; i < n; i++) begin
            check_eq("imem_addr", (i < addr_log.size()) ? addr_log[i] : -1, (base + i) % 512);
        end
    endtask

    initial begin
        int exp_loads;
        logic [3:0] exp_ack;

        // Reset and idle
        repeat (2) @(negedge clk);
        check_eq("rst_ctl", {3'b0, acc_ack, acc_end, col_e, rst_col, conf_we, conf_re, pc_e, col_start},
                 32'd0);
        check_eq("rst_mem", {14'b0, conf_ack, conf_req, ker_id_o, imem_radd}, 32'd0);
        check_eq("rst_pc", {12'b0, rcs_pc}, 32'd0);
        rst = 1'b0;
        clear_logs();
        repeat (5) @(negedge clk);
        check_eq("idle_ctl", {3'b0, acc_ack, acc_end, col_e, rst_col, conf_we, conf_re, pc_e, col_start},
                 32'd0);
        check_eq("idle_noreq", addr_log.size(), 0);

        // Load kernel 3 into columns 0,1 from slot 1
        launch(4'b0010, 4'd3);
        wait_start();
        check_addrs(16, 6);
        check_eq("we_cnt", we_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_eq("we_col_pc", (i < we_log.size()) ? we_log[i] : -1, (i < 3) ? i : 32 + i - 3);
        end
        check_eq("ack_cnt", ack_log.size(), 2);
        check_eq("ack0", {28'b0, (ack_log.size() > 0) ? ack_log[0] : 4'hf}, 32'd1);
        check_eq("ack1", {28'b0, (ack_log.size() > 1) ? ack_log[1] : 4'hf}, 32'd2);
        check_eq("col_start", {28'b0, col_start}, 32'd3);
        check_eq("start_rst", {28'b0, rst_col}, 32'hf);
        check_eq("start_col_e", {28'b0, col_e}, 32'd3);

        // Stall on masked column freezes both PCs
        data_stall = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_pc_e", {28'b0, pc_e}, 32'd0);
            check_eq("stall_pcs", {22'b0, rcs_pc[1], rcs_pc[0]}, 32'd0);
        end
        data_stall = 4'b0100;
        #1;
        check_eq("unmasked_stall", {28'b0, pc_e}, 32'd3);
        check_eq("exec_re", {28'b0, conf_re}, 32'd3);
        check_eq("exec_rst", {28'b0, rst_col}, 32'hc);
        @(negedge clk);
        check_eq("pc_inc", {22'b0, rcs_pc[1], rcs_pc[0]}, {22'b0, 5'd1, 5'd1});
        br_req    = 4'b0011;
        br_add[0] = 5'd7;
        br_add[1] = 5'd7;
        @(negedge clk);
        check_eq("pc_branch", {22'b0, rcs_pc[1], rcs_pc[0]}, {22'b0, 5'd7, 5'd7});
        br_req     = 4'b0;
        exec_end   = 4'b0011;
        data_stall = 4'b0010;
        #1;
        check_eq("end_vs_stall", {28'b0, acc_end}, 32'd2);
        check_eq("end_pc_e", {28'b0, pc_e}, 32'd0);
        @(negedge clk);
        exec_end   = 4'b0;
        data_stall = 4'b0;
        #1;
        check_eq("post_end", {20'b0, col_e, conf_re, acc_end}, 32'd0);

        // Lowest request wins; address wraps past 511
        launch(4'b1010, 4'd6);
        wait_start();
        check_addrs(510, 4);
        check_eq("wrap_we_last", (we_log.size() == 4) ? we_log[3] : -1, 64 + 3);
        check_eq("wrap_start", {28'b0, col_start}, 32'd4);
        end_kernel(4'b0100, 4'b0010);

        // Empty mask: ack then end, no imem traffic
        launch(4'b0001, 4'd5);
        @(negedge clk);
        check_eq("mask0_end", {28'b0, acc_end}, 32'd1);
        @(negedge clk);
        check_eq("mask0_end_clr", {28'b0, acc_end}, 32'd0);
        check_eq("mask0_noreq", addr_log.size(), 0);

        // Reset mid-load aborts immediately
        gnt_en = 1'b0;
        launch(4'b0001, 4'd3);
        repeat (2) @(negedge clk);
        check_eq("load_req", {31'b0, conf_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort", {15'b0, conf_req, col_e, rst_col, imem_radd}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        gnt_en = 1'b1;

        // Same kernel twice: second launch may come from the cache
        launch(4'b0001, 4'd3);
        wait_start();
        end_kernel(4'b0011, 4'b0001);
        launch(4'b0001, 4'd3);
        wait_start();
`ifdef CGRA_CTRL_CONF_CACHE_EN
        exp_loads = 0;
        exp_ack   = 4'b0011;
`else
        exp_loads = 6;
        exp_ack   = 4'b0000;
`endif
        check_eq("relaunch_loads", addr_log.size(), exp_loads);
        check_eq("relaunch_start", {28'b0, col_start}, 32'd3);
        check_eq("relaunch_ack", {28'b0, conf_ack}, {28'b0, exp_ack});
        end_kernel(4'b0011, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
